simon_seq_ctrl: RTL and testbench

- Game sequencer for the Simon Says sequence memory (30 x 2-bit colours, 5-bit pointers, negedge-clocked, registered read).
- Each round it appends one pseudo-random colour, plays the whole sequence on the LEDs, then checks the player's button presses against memory.
- Sits between the button/LED front end and the sequence memory, and is the only master of the memory ports.

---
 rtl/simon_pkg.sv | 36 +++
 rtl/simon_lfsr.sv | 28 ++
 rtl/simon_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_simon_seq_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// simon_pkg: shared types and constants for the Simon Says game sequencer.
//   color_t     - 2-bit button/LED colour
//   ptr_t       - 5-bit sequence memory address
//   seq_state_t - sequencer FSM states
//   MEM_DEPTH   - number of entries in the sequence memory
//   max_u()     - helper for sizing counters from parameters
package simon_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef logic [4:0] ptr_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_APPEND,
    S_PLAY_RD,
    S_PLAY_SHOW,
    S_PLAY_GAP,
    S_IN_RD,
    S_IN_WAIT,
    S_WIN,
    S_LOSE
  } seq_state_t;

  localparam int unsigned MEM_DEPTH = 30;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// simon_lfsr: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
//   clk   in  system clock, advances on every posedge
//   rst_n in  asynchronous active-low reset, loads SEED
//   rnd   out low two bits of the current LFSR state
// SEED must be non-zero, otherwise the register locks up at zero.
module simon_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] rnd
);

  logic [15:0] state;
  logic        fb;

  assign fb  = state[15] ^ state[13] ^ state[12] ^ state[10];
  assign rnd = state[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= {state[14:0], fb};
    end
  end

endmodule

// File: rtl/simon_seq_ctrl.sv
// simon_seq_ctrl: Simon Says game sequencer.
// Each round appends one pseudo-random colour to the sequence memory, plays
// the whole sequence on the LED, then checks player presses against memory.
// The sequence memory is negedge-clocked with a registered read port, so a
// read issued in one cycle is available at the posedge ending that cycle;
// r_ptr is held until the next read is issued.
//
// Ports:
//   clk          in   system clock (posedge)
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle pulse, starts a game (ignored while busy)
//   btn_valid    in   one-cycle pulse, one player press
//   btn_color    in   colour of the press
//   mem_data_in  out  memory write data, [1:0] colour, [5:2] zero
//   mem_w_ptr    out  memory write address
//   mem_r_ptr    out  memory read address
//   mem_w_en     out  memory write enable
//   mem_r_en     out  memory read enable
//   mem_data_out in   memory read data, only [1:0] used
//   led_en       out  LED lit
//   led_color    out  colour shown on the LED
//   level        out  current sequence length
//   busy         out  game in progress (not IDLE/WIN/LOSE)
//   win          out  held high in WIN
//   lose         out  held high in LOSE
//
// Optional feature: define SIMON_TIMEOUT_EN to lose the game when no press
// arrives within TIMEOUT_CYCLES cycles of entering the input-wait state.
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 30,
  parameter int unsigned SHOW_CYCLES    = 16,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_color,
  output logic [5:0] mem_data_in,
  output logic [4:0] mem_w_ptr,
  output logic [4:0] mem_r_ptr,
  output logic       mem_w_en,
  output logic       mem_r_en,
  input  logic [5:0] mem_data_out,
  output logic       led_en,
  output logic [1:0] led_color,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  // One shared phase counter serves show, gap and timeout timing.
  localparam int unsigned CNT_MAX = max_u(max_u(SHOW_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  seq_state_t       state;
  ptr_t             idx;
  logic [CNT_W-1:0] cnt;
  color_t           exp_color;
  logic [1:0]       rnd;
  logic             unused_data_hi;

  assign unused_data_hi = ^mem_data_out[5:2];

  simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .rnd   (rnd)
  );

  // Write data is taken from the LFSR in the APPEND cycle itself and forced
  // to zero whenever no write is in progress.
  assign mem_data_in = mem_w_en ? {4'b0000, rnd} : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      cnt       <= '0;
      exp_color <= RED;
      mem_w_ptr <= '0;
      mem_r_ptr <= '0;
      mem_w_en  <= 1'b0;
      mem_r_en  <= 1'b0;
      led_en    <= 1'b0;
      led_color <= '0;
      level     <= '0;
      busy      <= 1'b0;
      win       <= 1'b0;
      lose      <= 1'b0;
    end else begin
      mem_w_en <= 1'b0;
      mem_r_en <= 1'b0;
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            state     <= S_APPEND;
            level     <= '0;
            mem_w_en  <= 1'b1;
            mem_w_ptr <= '0;
            busy      <= 1'b1;
            win       <= 1'b0;
            lose      <= 1'b0;
          end
        end
        S_APPEND: begin
          level     <= level + 5'd1;
          idx       <= '0;
          mem_r_en  <= 1'b1;
          mem_r_ptr <= '0;
          state     <= S_PLAY_RD;
        end
        S_PLAY_RD: begin
          led_en    <= 1'b1;
          led_color <= mem_data_out[1:0];
          cnt       <= '0;
          state     <= S_PLAY_SHOW;
        end
        S_PLAY_SHOW: begin
          if (cnt == CNT_W'(SHOW_CYCLES - 1)) begin
            led_en <= 1'b0;
            cnt    <= '0;
            state  <= S_PLAY_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PLAY_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            mem_r_en <= 1'b1;
            if ((idx + 5'd1) == level) begin
              idx       <= '0;
              mem_r_ptr <= '0;
              state     <= S_IN_RD;
            end else begin
              idx       <= idx + 5'd1;
              mem_r_ptr <= idx + 5'd1;
              state     <= S_PLAY_RD;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IN_RD: begin
          // Any press in this cycle is dropped; the expected colour is not
          // available until the posedge that ends it.
          exp_color <= color_t'(mem_data_out[1:0]);
          cnt       <= '0;
          state     <= S_IN_WAIT;
        end
        S_IN_WAIT: begin
          if (btn_valid) begin
            if (btn_color != exp_color) begin
              busy  <= 1'b0;
              lose  <= 1'b1;
              state <= S_LOSE;
            end else if ((idx + 5'd1) != level) begin
              idx       <= idx + 5'd1;
              mem_r_ptr <= idx + 5'd1;
              mem_r_en  <= 1'b1;
              state     <= S_IN_RD;
            end else if (level == 5'(MAX_LEN)) begin
              busy  <= 1'b0;
              win   <= 1'b1;
              state <= S_WIN;
            end else begin
              mem_w_en  <= 1'b1;
              mem_w_ptr <= level;
              state     <= S_APPEND;
            end
          end
`ifdef SIMON_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            busy  <= 1'b0;
            lose  <= 1'b1;
            state <= S_LOSE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_seq_ctrl.sv
// tb_simon_seq_ctrl: directed self-checking bench for simon_seq_ctrl with a
// behavioural negedge sequence memory and a reference LFSR.
module tb_simon_seq_ctrl;

  localparam int unsigned MAXL = 3;
  localparam int unsigned SHOW = 16;
  localparam int unsigned GAP  = 8;
  localparam int unsigned TO   = 20;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       btn_valid;
  logic [1:0] btn_color;
  logic [5:0] mem_data_in;
  logic [4:0] mem_w_ptr;
  logic [4:0] mem_r_ptr;
  logic       mem_w_en;
  logic       mem_r_en;
  logic [5:0] mem_data_out;
  logic       led_en;
  logic [1:0] led_color;
  logic [4:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  logic [15:0] m;
  logic [5:0]  mem [0:31];
  logic [1:0]  exp_seq [0:31];

  simon_seq_ctrl #(
    .MAX_LEN        (MAXL),
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .LFSR_SEED      (16'hACE1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .btn_valid    (btn_valid),
    .btn_color    (btn_color),
    .mem_data_in  (mem_data_in),
    .mem_w_ptr    (mem_w_ptr),
    .mem_r_ptr    (mem_r_ptr),
    .mem_w_en     (mem_w_en),
    .mem_r_en     (mem_r_en),
    .mem_data_out (mem_data_out),
    .led_en       (led_en),
    .led_color    (led_color),
    .level        (level),
    .busy         (busy),
    .win          (win),
    .lose         (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, seeded on reset, steps every posedge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 16'hACE1;
    else        m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  // Sequence memory: negedge write and registered read.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 6'h3F;
    mem_data_out = '0;
  end
  always @(negedge clk) begin
    if (mem_w_en) mem[mem_w_ptr] <= mem_data_in;
    if (mem_r_en) mem_data_out <= mem[mem_r_ptr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Entered in the APPEND cycle of round n; returns in the IN_RD cycle.
  task automatic enter_round(input int n);
    int hi;
    int dark;
    logic [4:0] eptr;
    checks++;
    if (mem_w_en !== 1'b1 || mem_w_ptr !== 5'(n - 1)) begin
      errors++;
      $display("FAIL append_r%0d w_en=%0b w_ptr=%0d expected 1/%0d", n, mem_w_en, mem_w_ptr, n - 1);
    end
    checks++;
    if (mem_data_in !== {4'b0000, m[1:0]}) begin
      errors++;
      $display("FAIL append_data_r%0d got %h expected %h", n, mem_data_in, {4'b0000, m[1:0]});
    end
    exp_seq[n - 1] = m[1:0];
    tick;
    checks++;
    if (level !== 5'(n) || mem_r_en !== 1'b1 || mem_r_ptr !== 5'd0 || led_en !== 1'b0) begin
      errors++;
      $display("FAIL play_rd_r%0d level=%0d r_en=%0b r_ptr=%0d led=%0b expected %0d/1/0/0",
               n, level, mem_r_en, mem_r_ptr, led_en, n);
    end
    for (int i = 0; i < n; i++) begin
      tick;
      checks++;
      if (led_en !== 1'b1 || led_color !== exp_seq[i]) begin
        errors++;
        $display("FAIL show_r%0d_e%0d led=%0b color=%0d expected 1/%0d", n, i, led_en, led_color, exp_seq[i]);
      end
      hi = 0;
      while (led_en === 1'b1 && hi < 64) begin hi++; tick; end
      checks++;
      if (hi != int'(SHOW)) begin
        errors++;
        $display("FAIL show_len_r%0d_e%0d got %0d expected %0d", n, i, hi, SHOW);
      end
      dark = 0;
      while (led_en === 1'b0 && mem_r_en === 1'b0 && dark < 64) begin dark++; tick; end
      checks++;
      if (dark != int'(GAP)) begin
        errors++;
        $display("FAIL gap_len_r%0d_e%0d got %0d expected %0d", n, i, dark, GAP);
      end
      eptr = (i + 1 < n) ? 5'(i + 1) : 5'd0;
      checks++;
      if (mem_r_en !== 1'b1 || mem_r_ptr !== eptr) begin
        errors++;
        $display("FAIL next_rd_r%0d_e%0d r_en=%0b r_ptr=%0d expected 1/%0d", n, i, mem_r_en, mem_r_ptr, eptr);
      end
    end
  endtask

  // Entered in the first IN_RD cycle; presses the sequence, the entry at
  // bad_at (if >= 0) with a wrong colour. noise adds a wrong press during IN_RD.
  task automatic enter_inputs(input int n, input int bad_at, input bit noise);
    bit done;
    done = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      checks++;
      if (mem_r_en !== 1'b1 || mem_r_ptr !== 5'(i)) begin
        errors++;
        $display("FAIL in_rd_e%0d r_en=%0b r_ptr=%0d expected 1/%0d", i, mem_r_en, mem_r_ptr, i);
      end
      if (noise && i == 0) begin
        btn_valid = 1'b1;
        btn_color = exp_seq[0] ^ 2'b10;
      end
      tick;
      btn_valid = 1'b1;
      btn_color = (i == bad_at) ? (exp_seq[i] ^ 2'b01) : exp_seq[i];
      tick;
      btn_valid = 1'b0;
      if (i == bad_at) done = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_color = '0;
    #12;
    checks++;
    if ({busy, win, lose, led_en, mem_w_en, mem_r_en} !== 6'b0 || level !== 5'd0 ||
        mem_data_in !== 6'd0 || mem_w_ptr !== 5'd0 || mem_r_ptr !== 5'd0 || led_color !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs flags=%b level=%0d data=%h wp=%0d rp=%0d color=%0d expected all zero",
               {busy, win, lose, led_en, mem_w_en, mem_r_en}, level, mem_data_in, mem_w_ptr, mem_r_ptr, led_color);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) tick;
  endtask

  task automatic test_first_round;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || level !== 5'd0) begin
      errors++;
      $display("FAIL start_busy busy=%0b level=%0d expected 1/0", busy, level);
    end
    enter_round(1);
  endtask

  task automatic test_second_round;
    enter_inputs(1, -1, 1'b1);
    enter_round(2);
  endtask

  task automatic test_lose;
    enter_inputs(2, -1, 1'b0);
    enter_round(3);
    enter_inputs(3, 2, 1'b0);
    checks++;
    if (lose !== 1'b1 || busy !== 1'b0 || win !== 1'b0) begin
      errors++;
      $display("FAIL lose_flags lose=%0b busy=%0b win=%0b expected 1/0/0", lose, busy, win);
    end
    btn_valid = 1'b1; btn_color = exp_seq[0];
    tick;
    btn_valid = 1'b0;
    repeat (3) tick;
    checks++;
    if (lose !== 1'b1 || mem_w_en !== 1'b0 || mem_r_en !== 1'b0 || level !== 5'd3) begin
      errors++;
      $display("FAIL lose_hold lose=%0b w_en=%0b r_en=%0b level=%0d expected 1/0/0/3",
               lose, mem_w_en, mem_r_en, level);
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (lose !== 1'b0 || busy !== 1'b1 || level !== 5'd0) begin
      errors++;
      $display("FAIL restart lose=%0b busy=%0b level=%0d expected 0/1/0", lose, busy, level);
    end
    enter_round(1);
  endtask

  task automatic test_win;
    bit wr_seen;
    enter_inputs(1, -1, 1'b0);
    enter_round(2);
    enter_inputs(2, -1, 1'b0);
    enter_round(3);
    enter_inputs(3, -1, 1'b0);
    checks++;
    if (win !== 1'b1 || lose !== 1'b0 || busy !== 1'b0 || level !== 5'd3) begin
      errors++;
      $display("FAIL win_flags win=%0b lose=%0b busy=%0b level=%0d expected 1/0/0/3", win, lose, busy, level);
    end
    wr_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mem_w_en !== 1'b0) wr_seen = 1'b1;
      tick;
    end
    checks++;
    if (wr_seen !== 1'b0 || win !== 1'b1) begin
      errors++;
      $display("FAIL win_no_write wr_seen=%0b win=%0b expected 0/1", wr_seen, win);
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (led_en !== 1'b1 || mem_w_en !== 1'b0 || level !== 5'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored led=%0b w_en=%0b level=%0d busy=%0b expected 1/0/1/1",
               led_en, mem_w_en, level, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (led_en !== 1'b0 || mem_r_en !== 1'b0 || mem_w_en !== 1'b0 || busy !== 1'b0 || level !== 5'd0) begin
      errors++;
      $display("FAIL async_reset led=%0b r_en=%0b w_en=%0b busy=%0b level=%0d expected all 0",
               led_en, mem_r_en, mem_w_en, busy, level);
    end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      btn_valid = 1'b1; btn_color = 2'(i);
      tick;
      btn_valid = 1'b0;
      tick;
    end
    checks++;
    if (busy !== 1'b0 || mem_w_en !== 1'b0 || mem_r_en !== 1'b0 || led_en !== 1'b0 || lose !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%0b w_en=%0b r_en=%0b led=%0b lose=%0b expected all 0",
               busy, mem_w_en, mem_r_en, led_en, lose);
    end
  endtask

  task automatic test_timeout;
    start = 1'b1;
    tick;
    start = 1'b0;
    enter_round(1);
    tick;
`ifdef SIMON_TIMEOUT_EN
    repeat (TO - 1) tick;
    checks++;
    if (lose !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early lose=%0b busy=%0b expected 0/1", lose, busy);
    end
    tick;
    checks++;
    if (lose !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire lose=%0b busy=%0b expected 1/0", lose, busy);
    end
`else
    repeat (10000) tick;
    checks++;
    if (lose !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL no_timeout lose=%0b busy=%0b expected 0/1", lose, busy);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_first_round;
    test_second_round;
    test_lose;
    test_win;
    test_reset_mid;
    test_timeout;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
